// File: rtl/vga_timing_gen_if.sv
`timescale 1ns/1ps
// Raster timing bundle from vga_timing_gen to the drawing stages and VGA connector.
// frame_count exists only when FRAME_CNT_EN is defined.
interface vga_timing_gen_if;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic        hsync;
    logic        vsync;
    logic        video_on;
    logic        pix_tick;
    logic        frame_tick;
`ifdef FRAME_CNT_EN
    logic [15:0] frame_count;
`endif

    // Free-running strobes with no back-pressure: consumers sample on pix_tick/frame_tick.
    modport master (
`ifdef FRAME_CNT_EN
        output frame_count,
`endif
        output hcount, output vcount, output hsync, output vsync,
        output video_on, output pix_tick, output frame_tick
    );

    modport slave (
`ifdef FRAME_CNT_EN
        input frame_count,
`endif
        input hcount, input vcount, input hsync, input vsync,
        input video_on, input pix_tick, input frame_tick
    );
endinterface

// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
// vga_timing_gen: VGA raster counters, active-low syncs, pixel-enable and frame strobes.
// Optional macro FRAME_CNT_EN adds a 16-bit wrapping frame counter.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int CLK_DIV   = 2
) (
    input  logic             clk,
    input  logic             reset,
    vga_timing_gen_if.master vga
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div;
    logic             pix_tick;
    logic [9:0]       h_q, v_q;
    logic [9:0]       h_nx, v_nx;
    logic             hs_q, vs_q, vo_q, ft_q;
    logic             hs_nx, vs_nx, vo_nx, ft_nx;

    assign pix_tick = (div == DIV_LAST);

    // Next raster position and its decodes; only latched on a pix_tick edge,
    // so sync/video_on always describe the position they are registered with.
    always_comb begin
        h_nx = h_q + 10'd1;
        v_nx = v_q;
        if (h_q == H_LAST) begin
            h_nx = '0;
            v_nx = (v_q == V_LAST) ? '0 : v_q + 10'd1;
        end
        hs_nx = !((h_nx >= HS_START) && (h_nx < HS_END));
        vs_nx = !((v_nx >= VS_START) && (v_nx < VS_END));
        vo_nx = (h_nx < H_VIS) && (v_nx < V_VIS);
        ft_nx = (h_nx == '0) && (v_nx == V_VIS);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div  <= '0;
            h_q  <= '0;
            v_q  <= '0;
            hs_q <= 1'b1;
            vs_q <= 1'b1;
            vo_q <= 1'b1;
            ft_q <= 1'b0;
        end else begin
            ft_q <= 1'b0;
            if (pix_tick) begin
                div  <= '0;
                h_q  <= h_nx;
                v_q  <= v_nx;
                hs_q <= hs_nx;
                vs_q <= vs_nx;
                vo_q <= vo_nx;
                ft_q <= ft_nx;
            end else begin
                div <= div + DIV_W'(1);
            end
        end
    end

`ifdef FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt_q <= '0;
        end else if (pix_tick && ft_nx) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign vga.frame_count = frame_cnt_q;
`endif

    assign vga.hcount     = h_q;
    assign vga.vcount     = v_q;
    assign vga.hsync      = hs_q;
    assign vga.vsync      = vs_q;
    assign vga.video_on   = vo_q;
    assign vga.pix_tick   = pix_tick;
    assign vga.frame_tick = ft_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
// Bench for vga_timing_gen on a shrunk raster (24x14) so whole frames fit in a short run;
// two instances cover CLK_DIV=2 and CLK_DIV=3 against a closed-form position model.
module tb_vga_timing_gen;

    localparam int HV = 16, HFP = 2, HSW = 3, HBP = 3;
    localparam int VV = 8,  VFP = 2, VSW = 2, VBP = 2;
    localparam int HT = HV + HFP + HSW + HBP;   // 24
    localparam int VT = VV + VFP + VSW + VBP;   // 14
    localparam int FR = HT * VT;                // pixels per frame
    localparam int OFF = VV * HT;               // pixel index of (0,VV)

    typedef struct packed {
        logic [9:0]  h;
        logic [9:0]  v;
        logic        hs;
        logic        vs;
        logic        vo;
        logic        pt;
        logic        ft;
        logic [15:0] fc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [31:0] exp_q[$];

    vga_timing_gen_if vif2();
    vga_timing_gen_if vif3();

    vga_timing_gen #(.H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
                     .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
                     .CLK_DIV(2)) dut2 (.clk(clk), .reset(reset), .vga(vif2));

    vga_timing_gen #(.H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
                     .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
                     .CLK_DIV(3)) dut3 (.clk(clk), .reset(reset), .vga(vif3));

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // Edges since reset release; sampled on negedge so it is stable there.
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // ---------------- reference model ----------------
    // Position is simply (pixel ticks elapsed) mod frame, split into row/column.
    function automatic exp_t model(input int n, input int d);
        exp_t e;
        int t, p, h, v;
        t = n / d;
        p = t % FR;
        h = p % HT;
        v = p / HT;
        e.h  = 10'(h);
        e.v  = 10'(v);
        e.hs = !(h >= HV + HFP && h < HV + HFP + HSW);
        e.vs = !(v >= VV + VFP && v < VV + VFP + VSW);
        e.vo = (h < HV) && (v < VV);
        e.pt = (n % d) == (d - 1);
        e.ft = (n != 0) && (n % d == 0) && (p == OFF);
`ifdef FRAME_CNT_EN
        e.fc = (t >= OFF) ? 16'((t - OFF) / FR + 1) : 16'd0;
`else
        e.fc = 16'd0;
`endif
        return e;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic fresh_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({vif2.hcount, vif2.vcount} !== 20'd0) begin
            n_bad++;
            $display("FAIL reset_pos got h=%0d v=%0d want 0 0", vif2.hcount, vif2.vcount);
        end
        n_cmp++;
        if ({vif2.hsync, vif2.vsync, vif2.video_on, vif2.pix_tick, vif2.frame_tick} !== 5'b11100) begin
            n_bad++;
            $display("FAIL reset_flags got %b want 11100",
                     {vif2.hsync, vif2.vsync, vif2.video_on, vif2.pix_tick, vif2.frame_tick});
        end
        n_cmp++;
        if ({vif3.hcount, vif3.pix_tick, vif3.frame_tick} !== 12'd0) begin
            n_bad++;
            $display("FAIL reset_d3 got h=%0d pt=%b ft=%b want 0 0 0",
                     vif3.hcount, vif3.pix_tick, vif3.frame_tick);
        end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (vif2.pix_tick !== 1'b1 || vif2.hcount !== 10'd0) begin
            n_bad++;
            $display("FAIL release_cyc1 got pt=%b h=%0d want pt=1 h=0", vif2.pix_tick, vif2.hcount);
        end
        @(negedge clk);
        n_cmp++;
        if (vif2.pix_tick !== 1'b0 || vif2.hcount !== 10'd1) begin
            n_bad++;
            $display("FAIL release_cyc2 got pt=%b h=%0d want pt=0 h=1", vif2.pix_tick, vif2.hcount);
        end
    endtask

    task automatic test_line_wrap();
        int k;
        fresh_reset();
        k = 0;
        while (!(vif2.hcount == 10'(HT - 1) && vif2.vcount == 10'd2 && vif2.pix_tick) && k < 400) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (k >= 400) begin
            n_bad++;
            $display("FAIL line_wrap_reach got timeout want h=%0d v=2", HT - 1);
        end else begin
            @(negedge clk);
            if (vif2.hcount !== 10'd0 || vif2.vcount !== 10'd3 || vif2.video_on !== 1'b1) begin
                n_bad++;
                $display("FAIL line_wrap got h=%0d v=%0d vo=%b want h=0 v=3 vo=1",
                         vif2.hcount, vif2.vcount, vif2.video_on);
            end
        end
    endtask

    task automatic test_hsync();
        int k, lows, first_h, last_h;
        fresh_reset();
        k = 0;
        while (!(vif2.hcount == 10'd0 && vif2.vcount == 10'd1 && !vif2.pix_tick) && k < 200) begin
            @(negedge clk);
            k++;
        end
        lows = 0; first_h = -1; last_h = -1;
        for (int i = 0; i < HT * 2; i++) begin
            if (vif2.pix_tick) begin
                if (!vif2.hsync) begin
                    if (first_h < 0) first_h = int'(vif2.hcount);
                    last_h = int'(vif2.hcount);
                    lows++;
                end
                if (vif2.hcount == 10'(HV)) begin
                    n_cmp++;
                    if (vif2.video_on !== 1'b0) begin
                        n_bad++;
                        $display("FAIL video_off_edge got vo=%b want 0", vif2.video_on);
                    end
                end
                if (vif2.hcount == 10'(HV - 1)) begin
                    n_cmp++;
                    if (vif2.video_on !== 1'b1) begin
                        n_bad++;
                        $display("FAIL video_last_px got vo=%b want 1", vif2.video_on);
                    end
                end
            end
            @(negedge clk);
        end
        n_cmp++;
        if (lows != HSW || first_h != HV + HFP || last_h != HV + HFP + HSW - 1) begin
            n_bad++;
            $display("FAIL hsync_window got n=%0d first=%0d last=%0d want n=%0d first=%0d last=%0d",
                     lows, first_h, last_h, HSW, HV + HFP, HV + HFP + HSW - 1);
        end
    endtask

    task automatic test_vsync_frame();
        int win, falls, wraps;
        logic prev_vs;
        logic [9:0] prev_h, prev_v;
        win = 2 * FR * 2 + 200;
        exp_q.delete();
        for (int k = 0; (OFF + k * FR) * 2 <= win; k++) exp_q.push_back(32'((OFF + k * FR) * 2));
        fresh_reset();
        @(negedge clk);
        falls = 0; wraps = 0;
        prev_vs = vif2.vsync; prev_h = vif2.hcount; prev_v = vif2.vcount;
        while (cyc <= win) begin
            @(negedge clk);
            if (vif2.frame_tick) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL frame_tick_extra got tick at cyc=%0d want none", cyc);
                end else if (32'(cyc) !== exp_q[0] || vif2.vcount !== 10'(VV) || vif2.hcount !== 10'd0) begin
                    n_bad++;
                    $display("FAIL frame_tick got cyc=%0d h=%0d v=%0d want cyc=%0d h=0 v=%0d",
                             cyc, vif2.hcount, vif2.vcount, exp_q[0], VV);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
            end
            if (!vif2.vsync) begin
                n_cmp++;
                if (vif2.vcount < 10'(VV + VFP) || vif2.vcount >= 10'(VV + VFP + VSW)) begin
                    n_bad++;
                    $display("FAIL vsync_range got v=%0d low want %0d..%0d",
                             vif2.vcount, VV + VFP, VV + VFP + VSW - 1);
                end
            end
            if (prev_vs && !vif2.vsync) begin
                falls++;
                n_cmp++;
                if (vif2.frame_tick !== 1'b0 || vif2.vcount !== 10'(VV + VFP)) begin
                    n_bad++;
                    $display("FAIL vsync_fall got ft=%b v=%0d want ft=0 v=%0d",
                             vif2.frame_tick, vif2.vcount, VV + VFP);
                end
            end
            if (prev_h == 10'(HT - 1) && prev_v == 10'(VT - 1) && vif2.hcount != prev_h) begin
                wraps++;
                n_cmp++;
                if (vif2.hcount !== 10'd0 || vif2.vcount !== 10'd0) begin
                    n_bad++;
                    $display("FAIL frame_wrap got h=%0d v=%0d want 0 0", vif2.hcount, vif2.vcount);
                end
            end
            prev_vs = vif2.vsync; prev_h = vif2.hcount; prev_v = vif2.vcount;
        end
        n_cmp++;
        if (exp_q.size() != 0 || falls != 2 || wraps != 2) begin
            n_bad++;
            $display("FAIL frame_events got missing_ticks=%0d falls=%0d wraps=%0d want 0 2 2",
                     exp_q.size(), falls, wraps);
        end
    endtask

    task automatic test_async_reset();
        fresh_reset();
        repeat ((5 * HT + 12) * 2 + $urandom_range(0, 3)) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({vif2.hcount, vif2.vcount, vif2.hsync, vif2.vsync, vif2.video_on, vif2.pix_tick, vif2.frame_tick}
            !== {20'd0, 5'b11100}) begin
            n_bad++;
            $display("FAIL async_reset got h=%0d v=%0d flags=%b want h=0 v=0 flags=11100",
                     vif2.hcount, vif2.vcount,
                     {vif2.hsync, vif2.vsync, vif2.video_on, vif2.pix_tick, vif2.frame_tick});
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (vif2.hcount !== 10'd1 || vif2.vcount !== 10'd0 || vif2.frame_tick !== 1'b0) begin
            n_bad++;
            $display("FAIL async_restart got h=%0d v=%0d ft=%b want h=1 v=0 ft=0",
                     vif2.hcount, vif2.vcount, vif2.frame_tick);
        end
    endtask

    task automatic test_random();
        exp_t e, o;
        int len;
        for (int it = 0; it < 4; it++) begin
            @(negedge clk);
            #($urandom_range(1, 4));
            reset = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            reset = 1'b1;
            len = $urandom_range(100, 1600);
            for (int i = 0; i < len; i++) begin
                @(negedge clk);
                for (int d = 2; d <= 3; d++) begin
                    e = model(cyc, d);
                    if (d == 2) begin
                        o = '{h: vif2.hcount, v: vif2.vcount, hs: vif2.hsync, vs: vif2.vsync,
                              vo: vif2.video_on, pt: vif2.pix_tick, ft: vif2.frame_tick, fc: 16'd0};
`ifdef FRAME_CNT_EN
                        o.fc = vif2.frame_count;
`endif
                    end else begin
                        o = '{h: vif3.hcount, v: vif3.vcount, hs: vif3.hsync, vs: vif3.vsync,
                              vo: vif3.video_on, pt: vif3.pix_tick, ft: vif3.frame_tick, fc: 16'd0};
`ifdef FRAME_CNT_EN
                        o.fc = vif3.frame_count;
`endif
                    end
                    n_cmp++;
                    if (o !== e) begin
                        n_bad++;
                        $display("FAIL rand_d%0d cyc=%0d got h=%0d v=%0d flags=%b fc=%0d want h=%0d v=%0d flags=%b fc=%0d",
                                 d, cyc, o.h, o.v, {o.hs, o.vs, o.vo, o.pt, o.ft}, o.fc,
                                 e.h, e.v, {e.hs, e.vs, e.vo, e.pt, e.ft}, e.fc);
                    end
                end
            end
        end
    endtask

`ifdef FRAME_CNT_EN
    task automatic test_frame_count();
        int ticks, k;
        fresh_reset();
        ticks = 0; k = 0;
        while (ticks < 3 && k < 4 * FR * 2) begin
            @(negedge clk);
            if (vif2.frame_tick) ticks++;
            k++;
        end
        n_cmp++;
        if (ticks != 3 || vif2.frame_count !== 16'd3) begin
            n_bad++;
            $display("FAIL frame_count_3 got ticks=%0d fc=%0d want 3 3", ticks, vif2.frame_count);
        end
        force dut2.frame_cnt_q = 16'hffff;
        #1;
        release dut2.frame_cnt_q;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!vif2.frame_tick && k < FR * 2 + 10);
        n_cmp++;
        if (!vif2.frame_tick || vif2.frame_count !== 16'd0) begin
            n_bad++;
            $display("FAIL frame_count_wrap got ft=%b fc=%0d want ft=1 fc=0", vif2.frame_tick, vif2.frame_count);
        end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_line_wrap();
        test_hsync();
        test_vsync_frame();
        test_async_reset();
        test_random();
`ifdef FRAME_CNT_EN
        test_frame_count();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates 640x480@60 Hz VGA raster timing from the 50 MHz system clock.
- Drives hcount, vcount and vsync into the ball, paddle and collision stages, and hsync/vsync to the VGA connector.
- Adds a pixel-enable strobe and a synchronous once-per-frame pulse, so downstream logic can update game state without clocking on vsync edges.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 2, clk cycles per pixel; legal values 1 to 16

Ports:
- clk, input, 1, system clock
- reset, input, 1, asynchronous, active-low reset
- hcount, output, 10, current pixel column, 0 to H_TOTAL-1
- vcount, output, 10, current line, 0 to V_TOTAL-1
- hsync, output, 1, horizontal sync, active-low
- vsync, output, 1, vertical sync, active-low
- video_on, output, 1, high when (hcount,vcount) is in the visible area
- pix_tick, output, 1, one-clk pixel-enable strobe
- frame_tick, output, 1, one-clk pulse at start of vertical blank
- frame_count, output, 16, frames elapsed; present only with FRAME_CNT_EN

Behaviour:
- Derived constants: H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525).
- Reset (reset=0, takes effect immediately, no clock needed):
  - div=0, hcount=0, vcount=0
  - hsync=1, vsync=1, video_on=1, consistent with position (0,0)
  - frame_tick=0, frame_count=0
- Divider:
  - div is a register counting 0 to CLK_DIV-1 and wrapping.
  - pix_tick = (div == CLK_DIV-1).
  - CLK_DIV=1: pix_tick is constantly 1 out of reset.
  - CLK_DIV=2: the first hcount change occurs on the 2nd rising clk edge after reset deasserts.
- Counters advance only on an edge that ends a cycle with pix_tick=1:
  - hcount = hcount+1.
  - At H_TOTAL-1: hcount wraps to 0 and vcount increments.
  - At vcount = V_TOTAL-1 with hcount = H_TOTAL-1: both wrap to 0.
  - No other states exist; out-of-range values are unreachable.
- hsync, vsync and video_on are registered and updated on the same edge as the counters, computed from the NEW counter values. They are never skewed from hcount/vcount.
  - hsync = 0 iff H_VISIBLE+H_FP <= hcount < H_VISIBLE+H_FP+H_SYNC, i.e. 656 to 751.
  - vsync = 0 iff V_VISIBLE+V_FP <= vcount < V_VISIBLE+V_FP+V_SYNC, i.e. 490 to 491.
  - video_on = (hcount < H_VISIBLE) && (vcount < V_VISIBLE).
- frame_tick:
  - Registered; high for exactly one clk cycle following the edge at which (hcount,vcount) becomes (0,V_VISIBLE).
  - Low otherwise, including the cycle immediately after reset.
  - Period is H_TOTAL*V_TOTAL*CLK_DIV clk cycles, i.e. 840000.
- Counter states are sequential over clean lines: frame_tick and the vsync falling edge occur on different lines (480 vs 490) and never in the same cycle.
- Reset asserted mid-line or mid-frame: all state returns to reset values asynchronously. Counting restarts from (0,0) with a fresh divider phase; no partial frame_tick is produced.

Optional Feature:
- Macro: FRAME_CNT_EN.
- Defined:
  - The frame_count port exists.
  - It increments by 1 on the same edge that raises frame_tick and wraps 65535 to 0.
  - Reset value is 0.
- Undefined: the frame_count port and its register are absent. All other behaviour is identical.

Test Plan:
- Reset: hold reset=0 with clk running → hcount=0, vcount=0, hsync=1, vsync=1, video_on=1, pix_tick=0, frame_tick=0. Release reset → pix_tick=1 on cycle 1; hcount=1 after the 2nd edge.
- Line wrap: run to hcount=799, vcount=10, then one more pix_tick → hcount=0, vcount=11, video_on=1 in the same cycle.
- hsync: over one line, hsync is low for exactly 96 pix_ticks, first at hcount=656 and last at 751. video_on falls when hcount=640.
- vsync/frame: frame_tick is high for one cycle when vcount becomes 480. vsync is low only for vcount 490 to 491. Successive frame_ticks are 840000 clk cycles apart. Frame wraps (524,799) → (0,0).
- Async reset: assert reset=0 at hcount=300, vcount=200, between clk edges → outputs take reset values before the next edge. After release, timing matches the reset test.
- FRAME_CNT_EN defined: frame_count=3 after the 3rd frame_tick. Force-load 65535 → 0 on the next frame_tick. Build with the macro undefined and confirm all other tests still pass.
